// File: rtl/regfile_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_param : register file with hard-wired zero register and clear engine
// Optional REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Revision 1.0
// ----------------------------------------------------------------------------
module regfile_param #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              busy
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef logic [WIDTH-1:0] regs_t [NUM_REGS];

  // One extra bit so ZERO_REG == NUM_REGS never matches any real index.
  localparam logic [ADDR_W:0]   ZERO_IDX = ZERO_REG[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr;
  regs_t             mem;
  logic              wr_ok;
  logic              fwd1, fwd2;
  logic [WIDTH-1:0]  tree1, tree2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} == ZERO_IDX);
  endfunction

  // Binary reduction tree of 2:1 selects, LSB of the address at the leaves.
  function automatic logic [WIDTH-1:0] mux_tree(input regs_t regs,
                                                input logic [ADDR_W-1:0] addr);
    regs_t             lvl;
    logic [ADDR_W-1:0] a;
    lvl = regs;
    a   = addr;
    for (int s = 0; s < ADDR_W; s++) begin
      for (int k = 0; k < (NUM_REGS >> (s + 1)); k++) begin
        lvl[ADDR_W'(k)] = a[0] ? lvl[ADDR_W'(2 * k + 1)] : lvl[ADDR_W'(2 * k)];
      end
      a = a >> 1;
    end
    return lvl[0];
  endfunction

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_ptr == LAST_IDX) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  assign busy  = (state == CLEAR);
  assign wr_ok = (state == RUN) && wr_en && !is_zero(wr_addr);

  // Clear engine owns the storage whenever it runs; the write port only in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    tree1 = mux_tree(mem, rd_addr1);
    tree2 = mux_tree(mem, rd_addr2);
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_ok && (rd_addr1 == wr_addr);
  assign fwd2 = wr_ok && (rd_addr2 == wr_addr);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rd_data1 = (busy || is_zero(rd_addr1)) ? '0 : (fwd1 ? wr_data : tree1);
  assign rd_data2 = (busy || is_zero(rd_addr2)) ? '0 : (fwd2 ? wr_data : tree2);

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_param : directed bench for regfile_param with a per-cycle model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_regfile_param;

  localparam int          NR = 32;
  localparam logic [4:0]  ZA = 5'd31;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic [63:0] rd_data1, rd_data2;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_param dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after any reset edge everything is zero and reads are blanked for
  // NR further edges; afterwards writes land, except to register 31.
  logic [63:0] mem_m [NR];
  int          remaining = 0;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mvalid    <= 1'b1;
      remaining <= NR;
      for (int i = 0; i < NR; i++) mem_m[i] <= '0;
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
    end else if (wr_en && wr_addr != ZA) begin
      mem_m[wr_addr] <= wr_data;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (remaining > 0 || a == ZA) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != ZA && a == wr_addr) return wr_data;
`endif
    return mem_m[a];
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_busy", 64'(busy), 64'(remaining > 0));
      check("model_rd_data1", rd_data1, exp_rd(rd_addr1));
      check("model_rd_data2", rd_data2, exp_rd(rd_addr2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Counts sampled busy cycles from now; optionally tries a write one cycle in.
  task automatic count_clear(input string name, input bit inject_write);
    int cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      if (inject_write && i == 0) begin
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 64'hDEAD;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk);
      #3;
    end
    wr_en = 1'b0;
    check(name, 64'(cnt), 64'd32);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_reset", 64'(busy), 64'd1);
    check("rd1_in_reset", rd_data1, 64'd0);
    reset = 1'b0;
    #3;
    count_clear("busy_len_first", 1'b1);

    for (int i = 0; i <= 30; i++) begin
      cyc();
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(30 - i);
      #1;
      if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0) begin
        check("cleared_read1", rd_data1, 64'd0);
        check("cleared_read2", rd_data2, 64'd0);
      end
    end
    rd_addr1 = 5'd3;
    #1;
    check("write_during_busy_dropped", rd_data1, 64'd0);

    cyc();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0123_4567_89AB_CDEF;
    rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    cyc();
    wr_en = 1'b0; rd_addr2 = 5'd5;
    #1;
    check("reg5_port1", rd_data1, 64'h0123_4567_89AB_CDEF);
    check("reg5_port2", rd_data2, 64'h0123_4567_89AB_CDEF);
    rd_addr2 = 5'd6;
    #1;
    check("reg6_untouched", rd_data2, 64'd0);

    cyc(); wr_en = 1'b1; wr_addr = 5'd0;  wr_data = 64'h1111_2222_3333_4444;
    cyc(); wr_addr = 5'd30; wr_data = 64'hAAAA_5555_AAAA_5555;
    cyc(); wr_addr = 5'd17; wr_data = 64'h8000_0000_0000_0001;
    cyc(); wr_en = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd30;
    #1;
    check("reg0", rd_data1, 64'h1111_2222_3333_4444);
    check("reg30", rd_data2, 64'hAAAA_5555_AAAA_5555);
    rd_addr1 = 5'd17;
    #1;
    check("reg17", rd_data1, 64'h8000_0000_0000_0001);

    cyc();
    wr_en = 1'b1; wr_addr = ZA; wr_data = '1; rd_addr1 = ZA;
    #1;
    check("zero_reg_during_write", rd_data1, 64'd0);
    cyc();
    wr_en = 1'b0;
    #1;
    check("zero_reg_after_write", rd_data1, 64'd0);

    cyc();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hA5; rd_addr1 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd_data1, 64'hA5);
`else
    check("no_bypass_same_cycle", rd_data1, 64'd0);
`endif
    cyc();
    wr_en = 1'b0;
    #1;
    check("reg7_next_cycle", rd_data1, 64'hA5);

    cyc();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h55;
    cyc();
    wr_en = 1'b0; rd_addr1 = 5'd2;
    #1;
    check("reg2_written", rd_data1, 64'h55);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (10) cyc();
    check("busy_mid_clear", 64'(busy), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    count_clear("busy_len_restart", 1'b0);
    cyc();
    rd_addr1 = 5'd2; rd_addr2 = 5'd5;
    #1;
    check("reg2_after_restart", rd_data1, 64'd0);
    check("reg5_after_restart", rd_data2, 64'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
Name:
regfile_param

Overview:
- Parametrised register file that replaces the fixed 32x64 read-mux structure.
- Ports: one synchronous write port, two combinational read ports, a hard-wired zero register, and a sequential post-reset clear engine.
- Sits in the CPU decode/writeback stage, between the instruction decoder (read addresses) and the writeback mux (write data).
- Generalises register count, data width and zero-register index.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of two, >=2).
- WIDTH, 64, data width in bits.
- ZERO_REG, 31, index that always reads 0 and ignores writes; set to NUM_REGS to disable the zero register.
- ADDR_W, $clog2(NUM_REGS), address width (localparam, derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  WIDTH  write data.
- rd_addr1  input  ADDR_W  read port 1 index.
- rd_addr2  input  ADDR_W  read port 2 index.
- rd_data1  output  WIDTH  read port 1 data (combinational).
- rd_data2  output  WIDTH  read port 2 data (combinational).
- busy  output  1  high while the clear engine runs; writes ignored, reads return 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Storage: NUM_REGS x WIDTH flops. Storage is not reset directly; the clear engine zeroes it.
- FSM states: CLEAR, RUN.
  - reset=1 at a clock edge: state<=CLEAR, clr_ptr<=0. Storage entry 0 is written 0 on that edge.
  - In CLEAR with reset=0: entry clr_ptr is written 0, then clr_ptr increments.
  - When clr_ptr==NUM_REGS-1 in CLEAR: that entry is written 0, then state<=RUN.
  - CLEAR lasts exactly NUM_REGS cycles after reset deasserts.
  - RUN persists until the next reset.
- busy = (state==CLEAR). busy is 1 during reset and for NUM_REGS cycles after reset release, then 0.
- Write (RUN only): on a rising edge with wr_en=1 and wr_addr!=ZERO_REG, entry[wr_addr]<=wr_data.
  - wr_en while busy=1 is dropped, not queued.
  - Writes to ZERO_REG are dropped.
  - The clear engine has absolute priority over the write port.
- Read: rd_dataN = 0 if busy=1 or rd_addrN==ZERO_REG; otherwise entry[rd_addrN].
  - Purely combinational, zero latency.
  - Both ports are independent and may read the same address.
- Write-then-read latency: a write on edge T is visible on the read ports from edge T onward, i.e. in the cycle after wr_en was asserted. Same-cycle visibility applies only with the optional feature enabled.
- Output values during reset: rd_data1=rd_data2=0, busy=1.
- Reset mid-operation: any assertion, including during CLEAR, restarts the clear from entry 0. Prior contents are lost after completion.
- Read mux is built as a log2 tree of 2:1 selects, one tree per bit per port. No tristate or bus structures.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: a write-to-read forward path. If state==RUN, wr_en=1, wr_addr!=ZERO_REG and rd_addrN==wr_addr, then rd_dataN=wr_data in the same cycle (combinational bypass). Used by the single-cycle and pipelined datapaths to avoid a writeback hazard.
- Bypass is never active while busy=1 or for ZERO_REG.
- When not defined: no forwarding. rd_dataN shows the stored value, so the written value appears one cycle after the write edge.

Test Plan:
- Reset clear timing (NUM_REGS=32, WIDTH=64, ZERO_REG=31): hold reset 3 cycles, release -> busy=1 for exactly 32 cycles after release, then 0. rd_data1/rd_data2=0 for every address throughout. After busy falls, addresses 0..30 all read 0.
- Basic write/read: in RUN, write reg 5 = 64'h0123_4567_89AB_CDEF, then set rd_addr1=5 and rd_addr2=5 -> both ports return 64'h0123_4567_89AB_CDEF. Read of reg 6 stays 0.
- Zero register: write reg 31 = 64'hFFFF_FFFF_FFFF_FFFF -> rd_addr1=31 returns 0, in both bypass and non-bypass builds.
- Writes during busy: one cycle after reset release, wr_en=1, wr_addr=3, wr_data=64'hDEAD -> after busy=0, reg 3 reads 0.
- Bypass: reg 7 holds 0; same cycle wr_en=1, wr_addr=7, wr_data=64'hA5, rd_addr1=7.
  - With REGFILE_BYPASS_EN: rd_data1=64'hA5 in that cycle.
  - Without: rd_data1=0 in that cycle, 64'hA5 in the next cycle.
- Reset mid-operation: write reg 2=64'h55; assert reset for 1 cycle 10 cycles into a later CLEAR -> clear restarts, busy high 32 cycles after release, reg 2 reads 0 afterwards.
